// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM built-in self-test engine.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FIN     = 3'd5
    } bist_state_t;

    typedef enum logic [1:0] {
        MODE_ADDR     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_INV_ADDR = 2'd2,
        MODE_LFSR     = 2'd3
    } bist_mode_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sram_bist_if.sv
// User-side request bus between the BIST engine and sram_ctrl.
interface sram_bist_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    // A request transfers on the cycle where mem && ready; ready is low the
    // following cycle, and read data is valid the first cycle ready is high again.
    logic              mem;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic              ready;
    logic [DATA_W-1:0] data_s2f_r;

    modport master (output mem, rw, addr, data_f2s, input ready, data_s2f_r);
    modport slave  (input mem, rw, addr, data_f2s, output ready, data_s2f_r);
endinterface

// File: rtl/sram_pat_gen.sv
// Test-pattern source: LFSR register plus the per-mode pattern mux.
module sram_pat_gen
    import sram_bist_pkg::*;
#(
    parameter int          ADDR_W    = 18,
    parameter int          DATA_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lfsr_load,
    input  logic              lfsr_step,
    input  bist_mode_t        mode,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern
);

    localparam logic [DATA_W-1:0] CHK_ODD  = {DATA_W/2{2'b10}};
    localparam logic [DATA_W-1:0] CHK_EVEN = {DATA_W/2{2'b01}};

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr_load) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr_step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        pattern = '0;
        case (mode)
            MODE_ADDR:     pattern = DATA_W'(addr);
            MODE_CHECKER:  pattern = addr[0] ? CHK_ODD : CHK_EVEN;
            MODE_INV_ADDR: pattern = ~DATA_W'(addr);
            MODE_LFSR:     pattern = DATA_W'(lfsr);
            default:       pattern = '0;
        endcase
    end

endmodule

// File: rtl/sram_bist_ctrl.sv
// SRAM BIST engine: write pass then read/compare pass over [ADDR_LO, ADDR_HI].
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int          ADDR_W    = 18,
    parameter int          DATA_W    = 16,
    parameter int unsigned ADDR_LO   = 0,
    parameter int unsigned ADDR_HI   = 2**ADDR_W-1,
    parameter int          ERR_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    sram_bist_if.master       bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output bist_state_t       dbg_state
);

    localparam logic [ADDR_W-1:0] LO      = ADDR_W'(ADDR_LO);
    localparam logic [ADDR_W-1:0] HI      = ADDR_W'(ADDR_HI);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    bist_state_t       state;
    bist_mode_t        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_q;
    logic              rw_q;
    logic [DATA_W-1:0] pattern;
    logic              at_hi;
    logic              lfsr_load;
    logic              lfsr_step;

    assign at_hi     = (addr_q == HI);
    // Both passes restart the LFSR so read compares see the written sequence.
    assign lfsr_load = (state == IDLE && start) ||
                       (state == WR_WAIT && bus.ready && !abort && at_hi);
    assign lfsr_step = (state == WR_WAIT || state == RD_WAIT) &&
                       bus.ready && !abort && !at_hi;

    sram_pat_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_pat_gen (
        .clk       (clk),
        .reset     (reset),
        .lfsr_load (lfsr_load),
        .lfsr_step (lfsr_step),
        .mode      (mode_q),
        .addr      (addr_q),
        .pattern   (pattern)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            mode_q         <= MODE_ADDR;
            addr_q         <= '0;
            mem_q          <= 1'b0;
            rw_q           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
                mem_q <= 1'b0;
                rw_q  <= 1'b1;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        mode_q         <= bist_mode_t'(mode);
                        addr_q         <= LO;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        mem_q          <= 1'b1;
                        rw_q           <= 1'b0;
                        state          <= WR_REQ;
                    end
                    WR_REQ: if (bus.ready) begin
                        mem_q <= 1'b0;
                        rw_q  <= 1'b1;
                        state <= WR_WAIT;
                    end
                    WR_WAIT: if (bus.ready) begin
                        mem_q <= 1'b1;
                        if (at_hi) begin
                            addr_q <= LO;
                            rw_q   <= 1'b1;
                            state  <= RD_REQ;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            rw_q   <= 1'b0;
                            state  <= WR_REQ;
                        end
                    end
                    RD_REQ: if (bus.ready) begin
                        mem_q <= 1'b0;
                        state <= RD_WAIT;
                    end
                    RD_WAIT: if (bus.ready) begin
                        if (bus.data_s2f_r != pattern) begin
                            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                            if (err_cnt == '0) first_err_addr <= addr_q;
                        end
                        if (at_hi) begin
                            state <= FIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            mem_q  <= 1'b1;
                            state  <= RD_REQ;
                        end
                    end
                    FIN: begin
                        pass  <= (err_cnt == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem      = mem_q;
    assign bus.rw       = rw_q;
    assign bus.addr     = addr_q;
    assign bus.data_f2s = (state == WR_REQ) ? pattern : '0;
    assign dbg_state    = state;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: SRAM models with fault injection and a pattern-level reference.
module tb_sram_bist_ctrl;
    import sram_bist_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic        busy_a, done_a, pass_a;
    logic [15:0] err_a;
    logic [3:0]  first_a;
    bist_state_t st_a;
    logic        busy_b, done_b, pass_b;
    logic [2:0]  err_b;
    logic [3:0]  first_b;
    bist_state_t st_b;

    sram_bist_if #(.ADDR_W(4), .DATA_W(16)) bus_a ();
    sram_bist_if #(.ADDR_W(4), .DATA_W(16)) bus_b ();

    sram_bist_ctrl #(.ADDR_W(4), .DATA_W(16), .ADDR_LO(0), .ADDR_HI(15),
                     .ERR_W(16), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .bus(bus_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_err_addr(first_a), .dbg_state(st_a)
    );

    sram_bist_ctrl #(.ADDR_W(4), .DATA_W(16), .ADDR_LO(0), .ADDR_HI(15),
                     .ERR_W(3), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .bus(bus_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_err_addr(first_b), .dbg_state(st_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int run_acc0, run_done0;
    logic [20:0] exp_q[$];
    logic [15:0] wr_log[$];
    logic        exp_pass;
    logic [15:0] exp_err;
    logic [3:0]  exp_first;

    int          fa_addr = -2;
    logic [15:0] fa_and  = 16'hFFFF;
    logic [15:0] fa_or   = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_word(input int n);
        logic [15:0] w = 16'hACE1;
        for (int i = 0; i < n; i++) w = (w >> 1) ^ (w[0] ? 16'hB400 : 16'h0000);
        return w;
    endfunction

    function automatic logic [15:0] m_pat(input logic [1:0] md, input int a);
        case (md)
            2'd0:    return 16'(a);
            2'd1:    return (a % 2 == 1) ? 16'hAAAA : 16'h5555;
            2'd2:    return ~16'(a);
            default: return lfsr_word(a);
        endcase
    endfunction

    function automatic logic [15:0] fault_a(input logic [15:0] v, input int a);
        if (fa_addr == -1 || fa_addr == a) return (v & fa_and) | fa_or;
        return v;
    endfunction

    task automatic build_exp(input logic [1:0] md);
        int errs = 0;
        exp_q.delete();
        exp_first = 4'd0;
        for (int a = 0; a < 16; a++) exp_q.push_back({1'b0, 4'(a), m_pat(md, a)});
        for (int a = 0; a < 16; a++) begin
            exp_q.push_back({1'b1, 4'(a), 16'h0000});
            if (fault_a(m_pat(md, a), a) != m_pat(md, a)) begin
                if (errs == 0) exp_first = 4'(a);
                errs++;
            end
        end
        exp_err  = 16'(errs);
        exp_pass = (errs == 0);
    endtask

    // ---------------- SRAM models (2-cycle ready gap) ----------------
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    int          gap_a, gap_b;
    logic        pend_a, pend_b;
    logic [3:0]  paddr_a, paddr_b;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_a.ready <= 1'b1; bus_a.data_s2f_r <= 16'h0; gap_a <= 0; pend_a <= 1'b0;
        end else if (gap_a == 2) begin
            gap_a <= 1;
        end else if (gap_a == 1) begin
            gap_a <= 0;
            bus_a.ready <= 1'b1;
            if (pend_a) bus_a.data_s2f_r <= fault_a(mem_a[paddr_a], int'(paddr_a));
        end else if (bus_a.mem && bus_a.ready) begin
            bus_a.ready <= 1'b0; gap_a <= 2; pend_a <= bus_a.rw; paddr_a <= bus_a.addr;
            if (!bus_a.rw) mem_a[bus_a.addr] <= bus_a.data_f2s;
        end
    end

    // Second instance: every read comes back inverted.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_b.ready <= 1'b1; bus_b.data_s2f_r <= 16'h0; gap_b <= 0; pend_b <= 1'b0;
        end else if (gap_b == 2) begin
            gap_b <= 1;
        end else if (gap_b == 1) begin
            gap_b <= 0;
            bus_b.ready <= 1'b1;
            if (pend_b) bus_b.data_s2f_r <= ~mem_b[paddr_b];
        end else if (bus_b.mem && bus_b.ready) begin
            bus_b.ready <= 1'b0; gap_b <= 2; pend_b <= bus_b.rw; paddr_b <= bus_b.addr;
            if (!bus_b.rw) mem_b[bus_b.addr] <= bus_b.data_f2s;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (bus_a.mem && bus_a.ready) begin
                logic [20:0] e;
                acc_cnt++;
                if (!bus_a.rw) wr_log.push_back(bus_a.data_f2s);
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_rw", bus_a.rw, e[20]);
                    chk("acc_addr", bus_a.addr, e[19:16]);
                    if (!e[20]) chk("wr_data", bus_a.data_f2s, e[15:0]);
                end
            end
            if (!(bus_a.mem && !bus_a.rw)) chk("data_f2s_quiet", bus_a.data_f2s, 0);
            if (bus_a.mem) chk("busy_during_mem", busy_a, 1);
            if (done_a) begin
                done_cnt++;
                chk("done_pass", pass_a, exp_pass);
                chk("done_err_cnt", err_a, exp_err);
                chk("done_first_err", first_a, exp_first);
                chk("done_busy_low", busy_a, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [1:0] md, input logic [15:0] f_and,
                             input logic [15:0] f_or, input int f_addr);
        fa_and = f_and; fa_or = f_or; fa_addr = f_addr; mode = md;
        build_exp(md);
        run_acc0 = acc_cnt; run_done0 = done_cnt;
        wr_log.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Returns at the negedge just before the n-th matching accept edge.
    task automatic wait_acc(input int n, input logic want_rw);
        int cnt = 0;
        for (int i = 0; i < 600 && cnt < n; i++) begin
            @(negedge clk);
            if (bus_a.mem && bus_a.ready && bus_a.rw == want_rw) cnt++;
        end
        chk("accept_reached", cnt, n);
    endtask

    task automatic finish_run();
        logic seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        #1;
        chk("done_seen", seen, 1);
        chk("mem_pulses", acc_cnt - run_acc0, 32);
        chk("done_pulses", done_cnt - run_done0, 1);
        chk("exp_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int a0, d0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_first", first_a, 0);
        chk("rst_mem", bus_a.mem, 0);
        chk("rst_rw", bus_a.rw, 0);
        chk("rst_addr", bus_a.addr, 0);
        chk("rst_state", st_a, IDLE);
        reset = 1'b1;

        // Pin the model against hand-computed LFSR words.
        chk("model_lfsr0", lfsr_word(0), 16'hACE1);
        chk("model_lfsr1", lfsr_word(1), 16'hE270);
        chk("model_lfsr6", lfsr_word(6), 16'hB313);

        // Mode 0 clean; start and mode change while busy must be ignored.
        start_run(2'd0, 16'hFFFF, 16'h0000, -2);
        wait_acc(10, 1'b0);
        @(posedge clk); #1 start = 1'b1; mode = 2'd2;
        @(posedge clk); #1 start = 1'b0;
        finish_run();
        chk("t1_pass", pass_a, 1);
        chk("t1_err", err_a, 0);
        chk("t1_wr15", wr_log[15], 16'h000F);
        chk("sat_err_b", err_b, 7);
        chk("sat_first_b", first_b, 0);
        chk("sat_pass_b", pass_b, 0);

        // Checkerboard, bit 2 stuck-at-1 at address 5 (0xAAAA has bit 2 clear).
        start_run(2'd1, 16'hFFFF, 16'h0004, 5);
        finish_run();
        chk("t2_err", err_a, 1);
        chk("t2_first", first_a, 5);
        chk("t2_pass", pass_a, 0);
        chk("t2_wr4", wr_log[4], 16'h5555);

        // LFSR, data bit 0 stuck-at-0 everywhere.
        start_run(2'd3, 16'hFFFE, 16'h0000, -1);
        finish_run();
        chk("t3_err", err_a, 7);
        chk("t3_first", first_a, 0);
        chk("t3_pass", pass_a, 0);
        chk("t3_wr0", wr_log[0], 16'hACE1);
        chk("t3_wr1", wr_log[1], 16'hE270);
        chk("t3_wr5", wr_log[5], 16'h0E27);
        chk("t3_wr15", wr_log[15], 16'hBEC5);

        // Abort during the 4th read wait, then a clean rerun.
        start_run(2'd2, 16'hFFFF, 16'h0000, -2);
        wait_acc(4, 1'b1);
        @(posedge clk); #1;
        chk("t4_in_rd_wait", st_a, RD_WAIT);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("t4_busy", busy_a, 0);
        chk("t4_mem", bus_a.mem, 0);
        chk("t4_done", done_a, 0);
        chk("t4_pass", pass_a, 0);
        chk("t4_err_held", err_a, 0);
        exp_q.delete();
        a0 = acc_cnt; d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_no_access", acc_cnt - a0, 0);
        start_run(2'd2, 16'hFFFF, 16'h0000, -2);
        finish_run();
        chk("t4_rerun_pass", pass_a, 1);

        // Asynchronous reset in the middle of the write pass.
        start_run(2'd0, 16'hFFFF, 16'h0000, -2);
        wait_acc(5, 1'b0);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        chk("t5_busy", busy_a, 0);
        chk("t5_mem", bus_a.mem, 0);
        chk("t5_pass", pass_a, 0);
        chk("t5_err", err_a, 0);
        chk("t5_addr", bus_a.addr, 0);
        chk("t5_data", bus_a.data_f2s, 0);
        chk("t5_state", st_a, IDLE);
        exp_q.delete();
        a0 = acc_cnt; d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_access", acc_cnt - a0, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_idle", busy_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
